ar_id_gate: RTL and testbench

//  AR-channel admission stage placed directly upstream of the reorder buffer's AR slave port.

---
 rtl/rob_pkg.sv | 14 +
 rtl/id_scoreboard.sv | 51 +++++
 rtl/ar_id_gate.sv | 84 ++++++++
 tb/tb_ar_id_gate.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: ID width, ID type and counter-width helper.
// Imported by the AR admission stage and its scoreboard.
package rob_pkg;

    localparam int ID_WIDTH = 4;

    typedef logic [ID_WIDTH-1:0] id_t;

    // Bits needed to hold a count of 0..max inclusive.
    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// In-flight ID bitmap with set/clear ports, a lookup port and a sticky spurious-retire flag.
// Latency: set/clear visible on busy_o and lookup_busy the cycle after the request.
// Backpressure: none; the caller only sets free IDs and clears are ignored for idle IDs.
module id_scoreboard import rob_pkg::*; #(
    parameter int  ID_WIDTH = rob_pkg::ID_WIDTH,
    localparam int NID      = 2 ** ID_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_vld,
    input  logic [ID_WIDTH-1:0] set_id,
    input  logic                clr_vld,
    input  logic [ID_WIDTH-1:0] clr_id,
    input  logic [ID_WIDTH-1:0] lookup_id,
    output logic                lookup_busy,
    output logic                clr_ok,
    output logic [NID-1:0]      busy_o,
    output logic                err_o
);

    logic [NID-1:0] busy;
    logic [NID-1:0] busy_nxt;

    assign lookup_busy = busy[lookup_id];
    assign clr_ok      = clr_vld & busy[clr_id];
    assign busy_o      = busy;

    // Clear is applied before set so a different-ID retire and accept both land.
    always_comb begin
        busy_nxt = busy;
        if (clr_ok) begin
            busy_nxt[clr_id] = 1'b0;
        end
        if (set_vld) begin
            busy_nxt[set_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            err_o <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (clr_vld && !busy[clr_id]) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ar_id_gate.sv
// AR admission stage: blocks duplicate in-flight IDs and caps outstanding reads.
// Latency: one cycle from upstream accept to m_arvalid_o; 1 AR/cycle sustained.
// Backpressure: s_arready_o drops while the output slot is stalled, the ID is busy, or the cap is hit.
module ar_id_gate import rob_pkg::*; #(
    parameter int  ID_WIDTH        = rob_pkg::ID_WIDTH,
    parameter int  MAX_OUTSTANDING = 16,
    localparam int CW              = cnt_w(MAX_OUTSTANDING),
    localparam int NID             = 2 ** ID_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] s_arid_i,
    input  logic                s_arvalid_i,
    output logic                s_arready_o,
    output logic [ID_WIDTH-1:0] m_arid_o,
    output logic                m_arvalid_o,
    input  logic                m_arready_i,
    input  logic [ID_WIDTH-1:0] r_id_i,
    input  logic                r_valid_i,
    input  logic                r_ready_i,
    output logic [CW-1:0]       outstanding_o,
    output logic [NID-1:0]      busy_ids_o,
    output logic                err_o
);

    logic s_acc;
    logic m_acc;
    logic r_ret;
    logic ret_ok;
    logic id_busy;
    logic slot_free;
    logic below_cap;

    assign slot_free   = ~m_arvalid_o | m_arready_i;
    assign below_cap   = outstanding_o < CW'(MAX_OUTSTANDING);
    // Uses registered busy only: a same-cycle retire of this ID does not admit it yet.
    assign s_arready_o = slot_free & ~id_busy & below_cap;

    assign s_acc = s_arvalid_i & s_arready_o;
    assign m_acc = m_arvalid_o & m_arready_i;
    assign r_ret = r_valid_i & r_ready_i;

    id_scoreboard #(
        .ID_WIDTH (ID_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_vld     (s_acc),
        .set_id      (s_arid_i),
        .clr_vld     (r_ret),
        .clr_id      (r_id_i),
        .lookup_id   (s_arid_i),
        .lookup_busy (id_busy),
        .clr_ok      (ret_ok),
        .busy_o      (busy_ids_o),
        .err_o       (err_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_arid_o    <= '0;
            m_arvalid_o <= 1'b0;
        end else if (s_acc) begin
            m_arid_o    <= s_arid_i;
            m_arvalid_o <= 1'b1;
        end else if (m_acc) begin
            m_arvalid_o <= 1'b0;
        end
    end

    // Decrement only on a retire of a busy ID, so the count tracks the bitmap and cannot underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_o <= '0;
        end else begin
            case ({s_acc, ret_ok})
                2'b10:   outstanding_o <= outstanding_o + 1'b1;
                2'b01:   outstanding_o <= outstanding_o - 1'b1;
                default: outstanding_o <= outstanding_o;
            endcase
        end
    end

endmodule

// File: tb/tb_ar_id_gate.sv
// Bench for ar_id_gate: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a set-based model of in-flight IDs.
module tb_ar_id_gate;
    import rob_pkg::*;

    localparam int NID  = 2 ** ID_WIDTH;
    localparam int MAXO = 16;
    localparam int CW   = cnt_w(MAXO);

    logic            clk = 1'b0;
    logic            rst_n;
    id_t             s_arid;
    logic            s_arvalid;
    logic            s_arready;
    id_t             m_arid;
    logic            m_arvalid;
    logic            m_arready;
    id_t             r_id;
    logic            r_valid;
    logic            r_ready;
    logic [CW-1:0]   outstanding;
    logic [NID-1:0]  busy_ids;
    logic            err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ar_id_gate #(
        .ID_WIDTH        (ID_WIDTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_arid_i      (s_arid),
        .s_arvalid_i   (s_arvalid),
        .s_arready_o   (s_arready),
        .m_arid_o      (m_arid),
        .m_arvalid_o   (m_arvalid),
        .m_arready_i   (m_arready),
        .r_id_i        (r_id),
        .r_valid_i     (r_valid),
        .r_ready_i     (r_ready),
        .outstanding_o (outstanding),
        .busy_ids_o    (busy_ids),
        .err_o         (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit inflight[NID];
    bit mdl_mv;
    int mdl_mid;
    bit mdl_err;

    function automatic int popc();
        int n = 0;
        for (int k = 0; k < NID; k++) n += inflight[k];
        return n;
    endfunction

    function automatic logic [31:0] mdl_bitmap();
        logic [31:0] b = '0;
        for (int k = 0; k < NID; k++) b[k] = inflight[k];
        return b;
    endfunction

    function automatic bit mdl_ready();
        return (!mdl_mv || m_arready) && !inflight[s_arid] && (popc() < MAXO);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit rdy;
        bit sacc;
        bit macc;
        if (!rst_n) begin
            for (int k = 0; k < NID; k++) inflight[k] = 1'b0;
            mdl_mv  = 1'b0;
            mdl_mid = 0;
            mdl_err = 1'b0;
        end else begin
            rdy  = mdl_ready();
            sacc = s_arvalid && rdy;
            macc = mdl_mv && m_arready;
            if (r_valid && r_ready) begin
                if (inflight[r_id]) inflight[r_id] = 1'b0;
                else                mdl_err = 1'b1;
            end
            if (sacc) begin
                inflight[s_arid] = 1'b1;
                mdl_mv  = 1'b1;
                mdl_mid = int'(s_arid);
            end else if (macc) begin
                mdl_mv = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_arvalid", m_arvalid, mdl_mv);
        if (mdl_mv || !rst_n) chk("m_arid", m_arid, mdl_mid);
        chk("s_arready", s_arready, mdl_ready());
        chk("outstanding", outstanding, popc());
        chk("busy_ids", busy_ids, mdl_bitmap());
        chk("err", err, mdl_err);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input int id);
        r_id    = id_t'(id);
        r_valid = 1'b1;
        r_ready = 1'b1;
        step();
        r_valid = 1'b0;
    endtask

    initial begin
        int picks[$];
        s_arid = '0; s_arvalid = 1'b0; m_arready = 1'b1;
        r_id = '0; r_valid = 1'b0; r_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_outstanding", outstanding, 0);
        rst_n = 1'b1;
        #1 chk("rst_release_ready", s_arready, 1);

        // Streaming IDs 0..15
        for (int i = 0; i < 16; i++) begin
            s_arid = id_t'(i); s_arvalid = 1'b1;
            step();
            if (i == 0)  chk("stream_first_id", m_arid, 0);
            if (i == 15) chk("stream_last_id", m_arid, 15);
        end
        s_arid = 4'd0;
        #1;
        chk("stream_full_cnt", outstanding, 16);
        chk("stream_17th_ready", s_arready, 0);
        s_arvalid = 1'b0;
        for (int i = 0; i < 16; i++) retire(i);
        chk("stream_drained", outstanding, 0);

        // Duplicate ID 5
        s_arid = 4'd5; s_arvalid = 1'b1;
        step();
        repeat (3) begin
            #1 chk("dup_held", s_arready, 0);
            step();
        end
        r_id = 4'd5; r_valid = 1'b1; r_ready = 1'b1;
        #1 chk("dup_same_cycle", s_arready, 0);
        step();
        r_valid = 1'b0;
        #1 chk("dup_next_cycle", s_arready, 1);
        step();
        chk("dup_m_arid", m_arid, 5);
        chk("dup_m_arvalid", m_arvalid, 1);
        chk("dup_cnt", outstanding, 1);
        s_arvalid = 1'b0;
        retire(5);

        // Backpressure with ID 3 registered
        s_arid = 4'd3; s_arvalid = 1'b1;
        step();
        m_arready = 1'b0; s_arid = 4'd4;
        repeat (4) begin
            #1;
            chk("bp_id_stable", m_arid, 3);
            chk("bp_vld_stable", m_arvalid, 1);
            chk("bp_ready_low", s_arready, 0);
            step();
        end
        m_arready = 1'b1;
        #1 chk("bp_release_ready", s_arready, 1);
        step();
        chk("bp_id4_passes", m_arid, 4);
        s_arvalid = 1'b0;
        retire(3);
        retire(4);

        // Simultaneous accept of 9 and retire of 2 at outstanding 7
        for (int i = 0; i < 7; i++) begin
            s_arid = id_t'(i); s_arvalid = 1'b1;
            step();
        end
        s_arvalid = 1'b0;
        chk("sim_cnt_before", outstanding, 7);
        s_arid = 4'd9; s_arvalid = 1'b1;
        r_id = 4'd2; r_valid = 1'b1; r_ready = 1'b1;
        step();
        s_arvalid = 1'b0; r_valid = 1'b0;
        chk("sim_cnt_after", outstanding, 7);
        chk("sim_busy9", busy_ids[9], 1);
        chk("sim_busy2", busy_ids[2], 0);
        foreach (picks[k]) picks.delete(k);
        for (int i = 0; i < 7; i++) if (i != 2) retire(i);
        retire(9);
        chk("sim_drained", outstanding, 0);

        // Spurious retire of ID 12
        retire(12);
        chk("spur_err", err, 1);
        chk("spur_cnt", outstanding, 0);
        repeat (3) step();
        chk("spur_sticky", err, 1);

        // Randomized traffic with a reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                s_arvalid = 1'b1;
                rst_n = 1'b0;
                #1;
                chk("midrst_m_arvalid", m_arvalid, 0);
                chk("midrst_m_arid", m_arid, 0);
                chk("midrst_cnt", outstanding, 0);
                chk("midrst_busy", busy_ids, 0);
                chk("midrst_err", err, 0);
                step();
                step();
                rst_n = 1'b1; s_arvalid = 1'b0; r_valid = 1'b0; m_arready = 1'b1;
                #1 chk("midrst_ready", s_arready, 1);
            end
            s_arvalid = ($urandom_range(0, 3) != 0);
            s_arid    = id_t'($urandom_range(0, NID - 1));
            m_arready = ($urandom_range(0, 3) != 0);
            r_valid   = ($urandom_range(0, 2) == 0);
            r_ready   = ($urandom_range(0, 3) != 0);
            picks.delete();
            for (int k = 0; k < NID; k++) if (inflight[k]) picks.push_back(k);
            if (picks.size() == 0 || $urandom_range(0, 19) == 0)
                r_id = id_t'($urandom_range(0, NID - 1));
            else
                r_id = id_t'(picks[$urandom_range(0, picks.size() - 1)]);
            step();
        end
        s_arvalid = 1'b0; r_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
